// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared definitions: FSM state encoding and default geometry.
// Optional feature macro: MEM_CTRL_TIMEOUT_EN (see mem_ctrl.sv).
`timescale 1ns/1ps
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: bridges a shared tri-state CPU bus (MAR/MDR style) to a
// simple req/ack memory port. One transaction at a time.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   bus               shared bus, driven with MDR only while ram_out=1
//   mar_in            load MAR from bus[ADDR_W-1:0] (idle only)
//   mem_read          start a read at MAR (wins over mem_write)
//   mem_write         start a write of bus to MAR
//   ram_out           drive MDR onto bus (any state)
//   busy, done        transaction in progress / one-cycle completion
//   err               sticky timeout flag (MEM_CTRL_TIMEOUT_EN only)
//   mem_addr/wdata    MAR / MDR
//   mem_rdata         memory read data, captured at the ack edge
//   mem_req, mem_we   registered request and its direction
//   mem_ack           memory completion, honoured only in REQ
//
// Build option: define MEM_CTRL_TIMEOUT_EN to abort a request that
// receives no ack within TIMEOUT cycles and raise err.
`timescale 1ns/1ps
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              mar_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ram_out,
    output logic              busy,
    output logic              done,
`ifdef MEM_CTRL_TIMEOUT_EN
    output logic              err,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              req_q, req_d;
    logic              we_q, we_d;

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             err_q, err_d;
    logic             tmo;

    // tcnt_q holds the number of REQ cycles already elapsed, so the
    // request is abandoned at the end of its TIMEOUT-th cycle.
    assign tmo = (tcnt_q == CNT_W'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        req_d   = req_q;
        we_d    = we_q;
`ifdef MEM_CTRL_TIMEOUT_EN
        err_d   = err_q;
        tcnt_d  = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // MAR load and command share the edge, so a command
                // issued with mar_in uses the freshly loaded address.
                if (mar_in) begin
                    mar_d = bus[ADDR_W-1:0];
                end
                if (mem_read) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                end else if (mem_write) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    mdr_d   = bus;
                end
            end
            ST_REQ: begin
`ifdef MEM_CTRL_TIMEOUT_EN
                tcnt_d = tcnt_q + CNT_W'(1);
`endif
                if (mem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                    end
                end
`ifdef MEM_CTRL_TIMEOUT_EN
                else if (tmo) begin
                    // Give up: MDR keeps its previous contents.
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
            err_q   <= 1'b0;
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            req_q   <= req_d;
            we_q    <= we_d;
`ifdef MEM_CTRL_TIMEOUT_EN
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
`ifdef MEM_CTRL_TIMEOUT_EN
    assign err       = err_q;
`endif

    assign bus = ram_out ? mdr_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a transaction-level
// reference model, a scripted memory responder and literal spot checks.
`timescale 1ns/1ps
module tb_mem_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mar_in = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic          ram_out = 1'b0;
    logic [DW-1:0] bus_drv = '0;
    logic          bus_oe = 1'b0;
    wire  [DW-1:0] bus;
    logic          busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_req, mem_we;
    logic          mem_ack = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
    logic          err;
`endif

    assign bus = bus_oe ? bus_drv : {DW{1'bz}};

    mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mar_in    (mar_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ram_out   (ram_out),
        .busy      (busy),
        .done      (done),
`ifdef MEM_CTRL_TIMEOUT_EN
        .err       (err),
`endif
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Memory responder: acks after ack_wait extra request cycles
    // (ack_wait < 0 means never); force_ack drives a stray ack when idle.
    int   ack_wait = 0;
    logic force_ack = 1'b0;
    int   req_age = 0;

    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            mem_ack = (ack_wait >= 0) && (req_age == ack_wait);
            req_age++;
        end else begin
            req_age = 0;
            mem_ack = force_ack;
        end
    end

    // Reference model: one outstanding transaction, tracked as
    // idle / requesting / completing plus MAR and MDR contents.
    int            m_phase = 0;
    logic          m_we = 1'b0;
    logic          m_err = 1'b0;
    logic [AW-1:0] m_mar = '0;
    logic [DW-1:0] m_mdr = '0;
    int            m_wait = 0;
    int            cyc_n = 0;

    always @(posedge clk) begin
        cyc_n++;
        if (!rst) begin
            m_phase = 0;
            m_we    = 1'b0;
            m_err   = 1'b0;
            m_mar   = '0;
            m_mdr   = '0;
            m_wait  = 0;
        end else if (m_phase == 0) begin
            if (mar_in) m_mar = bus[AW-1:0];
            if (mem_read) begin
                m_phase = 1;
                m_we    = 1'b0;
                m_wait  = 0;
            end else if (mem_write) begin
                m_phase = 1;
                m_we    = 1'b1;
                m_mdr   = bus;
                m_wait  = 0;
            end
        end else if (m_phase == 1) begin
            m_wait++;
            if (mem_ack) begin
                if (!m_we) m_mdr = mem_rdata;
                m_phase = 2;
            end
`ifdef MEM_CTRL_TIMEOUT_EN
            else if (m_wait == TO) begin
                m_phase = 2;
                m_err   = 1'b1;
            end
`endif
        end else begin
            m_phase = 0;
        end
    end

    // Per-cycle compare plus activity totals for the directed checks.
    logic armed = 1'b0;
    int   req_total = 0;
    int   done_total = 0;
    int   last_done_cyc = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == 2);
            chk("mem_req", mem_req, m_phase == 1);
            if (m_phase == 1) chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_mar);
            chk("mem_wdata", mem_wdata, m_mdr);
`ifdef MEM_CTRL_TIMEOUT_EN
            chk("err", err, m_err);
`endif
            if (ram_out && !bus_oe) chk("bus_drive", bus, m_mdr);
            if (mem_req) req_total++;
            if (done) begin
                done_total++;
                last_done_cyc = cyc_n;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, d0, cmd_cyc;

        // Reset state
        step(2);
        armed = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);

        // Read at 0x2A, ack after two wait cycles
        step;
        rst = 1'b1;
        bus_oe = 1'b1; bus_drv = 16'h002A; mar_in = 1'b1;
        ack_wait = 2; mem_rdata = 16'h1234;
        step;
        mar_in = 1'b0; bus_oe = 1'b0; mem_read = 1'b1;
        r0 = req_total; d0 = done_total;
        step;
        mem_read = 1'b0;
        step(6);
        chk("rd_req_cycles", req_total - r0, 3);
        chk("rd_done_pulses", done_total - d0, 1);
        chk("rd_addr", mem_addr, 8'h2A);
        ram_out = 1'b1;
        @(negedge clk);
        chk("rd_bus", bus, 16'h1234);
        step;
        ram_out = 1'b0;

        // Write 0xBEEF to 0x05, ack in first request cycle
        bus_oe = 1'b1; bus_drv = 16'h0005; mar_in = 1'b1; ack_wait = 0;
        step;
        mar_in = 1'b0; bus_drv = 16'hBEEF; mem_write = 1'b1;
        cmd_cyc = cyc_n; d0 = done_total;
        step;
        mem_write = 1'b0; bus_oe = 1'b0;
        @(negedge clk);
        chk("wr_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 16'hBEEF);
        chk("wr_addr", mem_addr, 8'h05);
        step(4);
        chk("wr_latency", last_done_cyc - cmd_cyc, 2);
        chk("wr_done_pulses", done_total - d0, 1);

        // mar_in together with a read uses the new address
        bus_oe = 1'b1; bus_drv = 16'h0033; mar_in = 1'b1; mem_read = 1'b1;
        mem_rdata = 16'h0F0F;
        step;
        mar_in = 1'b0; mem_read = 1'b0; bus_oe = 1'b0;
        @(negedge clk);
        chk("mar_cmd_addr", mem_addr, 8'h33);
        step(3);

        // Read+write together: read wins; commands ignored while busy
        ack_wait = 1; mem_rdata = 16'h4321;
        bus_oe = 1'b1; bus_drv = 16'hAAAA; mem_read = 1'b1; mem_write = 1'b1;
        r0 = req_total; d0 = done_total;
        step;
        mem_read = 1'b0; mem_write = 1'b1; mar_in = 1'b1; bus_drv = 16'h0077;
        @(negedge clk);
        chk("both_we", mem_we, 0);
        step(2);
        mar_in = 1'b0; mem_write = 1'b0; bus_oe = 1'b0;
        step(3);
        chk("busy_addr", mem_addr, 8'h33);
        chk("busy_mdr", mem_wdata, 16'h4321);
        chk("busy_req_cycles", req_total - r0, 2);
        chk("busy_done", done_total - d0, 1);

        // Stray ack while idle is ignored
        force_ack = 1'b1;
        step(2);
        force_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_busy", busy, 0);
        step;

        // Reset in the middle of a request
        ack_wait = -1; mem_read = 1'b1; d0 = done_total;
        step;
        mem_read = 1'b0;
        step(2);
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        step;
        rst = 1'b0;
        step;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_mdr", mem_wdata, 0);
        step(2);
        chk("mid_rst_done", done_total - d0, 0);

        // Released bus: the bench value must be visible
        bus_oe = 1'b1; bus_drv = 16'h5A5A; ram_out = 1'b0;
        @(negedge clk);
        chk("hiz_bus", bus, 16'h5A5A);
        step;
        bus_oe = 1'b0;

`ifdef MEM_CTRL_TIMEOUT_EN
        // Timeout: never ack
        ack_wait = 0;
        bus_oe = 1'b1; bus_drv = 16'h1357; mem_write = 1'b1;
        step;
        mem_write = 1'b0; bus_oe = 1'b0;
        step(3);
        ack_wait = -1; mem_read = 1'b1;
        r0 = req_total; d0 = done_total;
        step;
        mem_read = 1'b0;
        step(20);
        chk("to_req_cycles", req_total - r0, 16);
        chk("to_done", done_total - d0, 1);
        chk("to_err", err, 1);
        chk("to_mdr", mem_wdata, 16'h1357);
        step(3);
        chk("to_err_sticky", err, 1);
        rst = 1'b0;
        step;
        rst = 1'b1;
        @(negedge clk);
        chk("to_err_rst", err, 0);
        step;
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
